// File: rtl/seq_alu_pkg.sv
// Shared opcode map, FSM state encoding and helpers for the sequential ALU.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_MULH = 4'd9;
    localparam logic [3:0] OP_DIVU = 4'd10;
    localparam logic [3:0] OP_REMU = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_e;

    typedef enum logic {
        MODE_MUL,
        MODE_DIV
    } dm_mode_e;

    function automatic logic is_iterative(input logic [3:0] oper);
        return (oper == OP_MUL) || (oper == OP_MULH) ||
               (oper == OP_DIVU) || (oper == OP_REMU);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response handshake bundle between decode, the ALU and writeback.
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       oper;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, a, b, oper, out_ready,
        input  in_ready, out_valid, result, zero, err
    );

    modport slave (
        input  in_valid, a, b, oper, out_ready,
        output in_ready, out_valid, result, zero, err
    );
endinterface

// File: rtl/seq_alu_divmul.sv
// Shared one-bit-per-cycle datapath: shift-add multiplier and restoring divider.
// acc holds {product hi, multiplier} for MUL and {remainder, quotient} for DIV.
module seq_alu_divmul
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  dm_mode_e         mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    dm_mode_e           mode_q, mode_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;

    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        sum     = '0;
        trial   = '0;
        if (start) begin
            mode_d  = mode;
            mcand_d = (mode == MODE_MUL) ? a : b;
            acc_d   = (mode == MODE_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
            cnt_d   = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (mode_q == MODE_MUL) begin
                sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
                acc_d = {sum, acc_q[WIDTH-1:1]};
            end else begin
                // Trial subtract on the shifted remainder; keep it only if non-negative.
                trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mcand_q};
                if (!trial[WIDTH]) begin
                    acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    // Final step's value is exposed so the top can register it on the same edge.
    assign done = (cnt_q == CW'(1));
    assign lo   = acc_d[WIDTH-1:0];
    assign hi   = acc_d[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_MUL;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle logic/arith ops plus iterative MUL/DIV.
// Owns the control FSM, result registers and the valid/ready interface.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic     clk,
    input logic     rst_n,
    seq_alu_if.slave bus
);
    localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             sel_hi_q, sel_hi_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_err;
    logic             is_div;
    logic             iterate;
    logic             dm_start;
    dm_mode_e         dm_mode;
    logic             dm_done;
    logic [WIDTH-1:0] dm_lo;
    logic [WIDTH-1:0] dm_hi;

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (bus.oper)
            OP_ADD:  alu_res = bus.a + bus.b;
            OP_SUB:  alu_res = bus.a - bus.b;
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_SLL:  alu_res = (bus.b >= WLIM) ? '0 : (bus.a << bus.b);
            OP_SRL:  alu_res = (bus.b >= WLIM) ? '0 : (bus.a >> bus.b);
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_MUL, OP_MULH: alu_res = '0;
            OP_DIVU: begin
                alu_res = '1;
                alu_err = 1'b1;
            end
            OP_REMU: begin
                alu_res = bus.a;
                alu_err = 1'b1;
            end
            default: alu_err = 1'b1;
        endcase
    end

    assign is_div  = (bus.oper == OP_DIVU) || (bus.oper == OP_REMU);
    assign iterate = is_iterative(bus.oper) && !(is_div && (bus.b == '0));
    assign dm_mode = is_div ? MODE_DIV : MODE_MUL;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
        sel_hi_d = sel_hi_q;
        dm_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (iterate) begin
                        dm_start = 1'b1;
                        sel_hi_d = (bus.oper == OP_MULH) || (bus.oper == OP_REMU);
                        state_d  = is_div ? DIV : MUL;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        err_d    = alu_err;
                        state_d  = DONE;
                    end
                end
            end
            MUL, DIV: begin
                if (dm_done) begin
                    result_d = sel_hi_q ? dm_hi : dm_lo;
                    zero_d   = ((sel_hi_q ? dm_hi : dm_lo) == '0);
                    err_d    = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            sel_hi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            sel_hi_q <= sel_hi_d;
        end
    end

    seq_alu_divmul #(
        .WIDTH(WIDTH)
    ) u_divmul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (dm_start),
        .mode  (dm_mode),
        .a     (bus.a),
        .b     (bus.b),
        .done  (dm_done),
        .lo    (dm_lo),
        .hi    (dm_hi)
    );

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8): driver queues hand-computed results,
// a negedge monitor pops and compares each accepted response.
module tb_seq_alu;
    import seq_alu_pkg::*;

    typedef struct {
        logic [7:0] res;
        logic       zero;
        logic       err;
        int         lat;
        int         acc_edge;
    } exp_t;

    logic clk;
    logic rst_n;
    int   edge_cnt = 0;
    int   passed = 0;
    int   total = 0;
    exp_t q[$];

    seq_alu_if #(.WIDTH(8)) bus ();

    seq_alu #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] r, input logic e, input int lat);
        exp_t x;
        int   n;
        @(posedge clk);
        #1;
        bus.oper     = op;
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            $display("FAIL accept_timeout op=%0d: in_ready stayed 0, expected 1 within 200 cycles", op);
            bus.in_valid = 1'b0;
            return;
        end
        x.res      = r;
        x.zero     = (r == 8'h00);
        x.err      = e;
        x.lat      = lat;
        x.acc_edge = edge_cnt + 1;
        q.push_back(x);
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the DUT must have captured them already.
        bus.in_valid = 1'b0;
        bus.a        = 8'hFF;
        bus.b        = 8'hFF;
        bus.oper     = OP_SUB;
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t       x;
        logic       prev_v = 1'b0;
        logic       busy_viol = 1'b0;
        logic       unstable = 1'b0;
        int         rise_edge = 0;
        int         last_cons = -1;
        logic [7:0] held_res = '0;
        logic       held_z = 1'b0;
        logic       held_e = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v    = 1'b0;
                busy_viol = 1'b0;
                unstable  = 1'b0;
                last_cons = -1;
                continue;
            end
            if (q.size() > 0 && edge_cnt >= q[0].acc_edge && bus.in_ready) busy_viol = 1'b1;
            if (bus.out_valid) begin
                if (!prev_v) begin
                    rise_edge = edge_cnt;
                    held_res  = bus.result;
                    held_z    = bus.zero;
                    held_e    = bus.err;
                end else if (bus.result !== held_res || bus.zero !== held_z || bus.err !== held_e) begin
                    unstable = 1'b1;
                end
                if (bus.out_ready) begin
                    if (q.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_output: result=0x%0h with no request outstanding", bus.result);
                    end else begin
                        x = q.pop_front();
                        check("result", bus.result, x.res);
                        check("zero", bus.zero, x.zero);
                        check("err", bus.err, x.err);
                        check("latency", rise_edge - x.acc_edge + 1, x.lat);
                        check("in_ready_low_while_busy", busy_viol, 0);
                        check("held_stable", unstable, 0);
                        if (last_cons >= 0) check("accept_after_consume", x.acc_edge > last_cons, 1);
                        last_cons = edge_cnt + 1;
                    end
                    busy_viol = 1'b0;
                    unstable  = 1'b0;
                end
            end
            prev_v = bus.out_valid;
        end
    end

    initial begin
        int n;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        bus.oper      = OP_ADD;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_zero", bus.zero, 0);
        check("rst_err", bus.err, 0);
        rst_n = 1'b1;

        issue(OP_ADD,  8'hF0, 8'h20, 8'h10, 1'b0, 1);
        issue(OP_SUB,  8'd5,  8'd5,  8'h00, 1'b0, 1);
        issue(OP_AND,  8'hCC, 8'hAA, 8'h88, 1'b0, 1);
        issue(OP_OR,   8'hCC, 8'hAA, 8'hEE, 1'b0, 1);
        issue(OP_XOR,  8'hCC, 8'hAA, 8'h66, 1'b0, 1);
        issue(OP_MUL,  8'd200, 8'd100, 8'h20, 1'b0, 9);
        issue(OP_MULH, 8'd200, 8'd100, 8'h4E, 1'b0, 9);
        issue(OP_MUL,  8'hFF, 8'hFF, 8'h01, 1'b0, 9);
        issue(OP_MULH, 8'hFF, 8'hFF, 8'hFE, 1'b0, 9);
        issue(OP_DIVU, 8'd200, 8'd7, 8'd28, 1'b0, 9);
        issue(OP_REMU, 8'd200, 8'd7, 8'd4,  1'b0, 9);
        issue(OP_DIVU, 8'd5,  8'd9,  8'd0,  1'b0, 9);
        issue(OP_REMU, 8'd5,  8'd9,  8'd5,  1'b0, 9);
        issue(OP_DIVU, 8'hFF, 8'd1,  8'hFF, 1'b0, 9);
        issue(OP_DIVU, 8'd9,  8'd0,  8'hFF, 1'b1, 1);
        issue(OP_REMU, 8'd9,  8'd0,  8'd9,  1'b1, 1);
        issue(OP_SRL,  8'hFF, 8'd8,  8'h00, 1'b0, 1);
        issue(OP_SRL,  8'h80, 8'd7,  8'h01, 1'b0, 1);
        issue(OP_SLL,  8'h01, 8'd200, 8'h00, 1'b0, 1);
        issue(OP_SLTU, 8'd3,  8'd4,  8'h01, 1'b0, 1);
        issue(OP_SLTU, 8'd4,  8'd3,  8'h00, 1'b0, 1);
        issue(4'd13,   8'h12, 8'h34, 8'h00, 1'b1, 1);

        // Backpressure: hold the result, queue a request behind it.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        issue(OP_SLL, 8'h81, 8'd1, 8'h02, 1'b0, 1);
        fork
            begin
                repeat (5) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join_none
        issue(OP_ADD, 8'h10, 8'h01, 8'h11, 1'b0, 1);

        // Asynchronous reset in the middle of a division.
        issue(OP_DIVU, 8'd9, 8'd0, 8'hFF, 1'b1, 1);
        issue(OP_DIVU, 8'd200, 8'd3, 8'd66, 1'b0, 9);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        q.delete();
        check("async_rst_in_ready", bus.in_ready, 1);
        check("async_rst_out_valid", bus.out_valid, 0);
        check("async_rst_result", bus.result, 0);
        check("async_rst_zero", bus.zero, 0);
        check("async_rst_err", bus.err, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        issue(OP_ADD, 8'd1, 8'd1, 8'd2, 1'b0, 1);
        issue(OP_MULH, 8'd16, 8'd16, 8'd1, 1'b0, 9);

        n = 0;
        while (q.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > 0) begin
            total++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
        end
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the processor's 8-bit combinational ALU. Keeps the same 4-bit opcode map and adds a WIDTH parameter.
- Replaces the combinational multiplier and divider with iterative shift-add and restoring-division engines.
- Sits between the decode/register-read stage and writeback. Takes one operation at a time over valid/ready and holds each result until writeback accepts it.

Parameters:
- WIDTH, 8, operand and result width in bits; legal values are 4 to 32.
- CW, $clog2(WIDTH+1), derived and not to be overridden; iteration counter width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- oper  input  4  opcode
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  result
- zero  output  1  result == 0
- err  output  1  divide-by-zero or illegal opcode

Behaviour:
- Opcode map:
  - 0 ADD, 1 SUB (both modulo 2^WIDTH)
  - 2 AND, 3 OR, 4 XOR
  - 5 SLL by unsigned b, 6 SRL by unsigned b; shift amount >= WIDTH gives 0
  - 7 SLTU gives 1/0
  - 8 MUL low WIDTH bits, 9 MULH high WIDTH bits of the 2*WIDTH product
  - 10 DIV, 11 REM (unsigned)
  - 12-15 illegal
- Reset (asynchronous, any state, including mid-iteration):
  - state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, err=0, counter=0
  - any operation in progress is discarded
- States: IDLE, MUL, DIV, DONE.
- Accept rule: an operation is accepted on the edge where in_valid && in_ready. in_ready=1 only in IDLE. Operands and opcode are captured on the accept edge; later input changes are ignored.
- IDLE transitions on accept:
  - ops 0-7 and 12-15: result computed and registered on the accept edge; go to DONE. out_valid rises the next cycle (latency 1).
  - op 8 or 9: load multiplicand, multiplier and a 2*WIDTH accumulator; counter=WIDTH; go to MUL.
  - op 10 or 11 with b!=0: load the restoring divider (remainder=0, quotient=a); counter=WIDTH; go to DIV.
  - op 10 or 11 with b==0: no iteration; result = all-ones (DIV) or a (REM); err=1; go to DONE (latency 1).
  - illegal ops: result=0, err=1.
- MUL/DIV: one bit per cycle; counter decrements. When counter reaches 0, select the low/high product half or quotient/remainder, register the result, and go to DONE. Total latency from accept edge to out_valid is WIDTH+1 cycles (9 for WIDTH=8).
- DONE:
  - out_valid=1
  - result, zero and err are held stable until out_valid && out_ready; on that edge go to IDLE, out_valid=0.
  - the next accept is possible no earlier than the following cycle; no same-cycle pass-through.
- zero is computed from the final registered result, including when err=1.
- out_ready has no effect outside DONE. in_valid has no effect outside IDLE; requests wait.
- No combinational path from in_valid/oper to out_*, or from out_ready to in_ready.

Decomposition:
- Package seq_alu_pkg holds:
  - opcode localparams OP_ADD to OP_REMU (0-11)
  - the state enumeration
  - a helper function is_iterative(oper)
- One natural sub-module is seq_alu_divmul: the shared shift/accumulate datapath for MUL and DIV, with start/done signals and a mode input. The top level owns the FSM, the single-cycle ops and the handshake.

Test Plan (WIDTH=8):
- ADD a=0xF0, b=0x20, out_ready=1 -> out_valid 1 cycle after accept; result=0x10, zero=0, err=0. SUB a=5, b=5 -> result=0x00, zero=1.
- MUL a=200, b=100 -> result=0x20 after 9 cycles. Same operands with MULH -> result=0x4E. in_ready=0 throughout both.
- DIV a=200, b=7 -> result=28; REM -> result=4; each latency 9. DIV a=9, b=0 -> result=0xFF, err=1, latency 1. REM a=9, b=0 -> result=9, err=1.
- Backpressure: hold out_ready=0 for 5 cycles after a SLL a=0x81, b=1 -> result=0x02 stable, out_valid held, in_ready=0. A new in_valid during the stall is not accepted until the cycle after out_ready=1.
- Edge cases: SRL a=0xFF, b=8 -> 0x00, zero=1. SLTU a=3, b=4 -> 1. Opcode 13 -> result=0, err=1, zero=1.
- Assert rst_n=0 at the 4th cycle of a DIV -> all outputs take reset values immediately (asynchronously). After release, ADD a=1, b=1 gives result=2 with normal latency.
